// File: rtl/tetris_pkg.sv
// Shared encodings for the board: row command bus values, the line-clear
// sequencer states and the default board geometry.
package tetris_pkg;

    localparam int DEFAULT_ROWS    = 20;
    localparam int DEFAULT_TOTAL_W = 16;

    typedef enum logic [1:0] {
        ROW_CHECK = 2'b00,
        ROW_MOVE  = 2'b01,
        ROW_WRITE = 2'b10,
        ROW_SHIFT = 2'b11
    } row_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CHECK,
        ST_CAPTURE,
        ST_SHIFT,
        ST_DONE
    } ctrl_state_t;

endpackage

// File: rtl/line_clear_ctrl_if.sv
// Connection between the line-clear sequencer (master) and the row stack /
// scoring side (slave).
interface line_clear_ctrl_if
    import tetris_pkg::*;
#(
    parameter int ROWS    = DEFAULT_ROWS,
    parameter int TOTAL_W = DEFAULT_TOTAL_W
);
    localparam int CNT_W = $clog2(ROWS + 1);

    logic               lock_req;
    logic [ROWS-1:0]    clear_flags;
    row_cmd_t           row_cmd;
    logic [ROWS-1:0]    shift_row;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   lines_cleared;
    logic [TOTAL_W-1:0] total_lines;

    modport master (
        input  lock_req, clear_flags,
        output row_cmd, shift_row, busy, done, lines_cleared, total_lines
    );

    modport slave (
        output lock_req, clear_flags,
        input  row_cmd, shift_row, busy, done, lines_cleared, total_lines
    );

endinterface

// File: rtl/row_pri_enc.sv
// Lowest-set-bit encoder: idx is the smallest index with mask[idx]=1, which on
// the board is the topmost flagged row. valid is low when mask is all zero.
module row_pri_enc #(
    parameter int W     = 20,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scanning downward lets the lowest set bit be the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: WRITE, CHECK, capture row flags, then one SHIFT per
// cleared row (topmost first), reporting per-lock and running line counts.
module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS    = DEFAULT_ROWS,
    parameter int TOTAL_W = DEFAULT_TOTAL_W
) (
    input  logic              clk,
    input  logic              reset,
    line_clear_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    ctrl_state_t        state;
    row_cmd_t           row_cmd;
    logic [ROWS-1:0]    shift_row;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   lines_cleared;
    logic [TOTAL_W-1:0] total_lines;
    logic [ROWS-1:0]    pending;
    logic [CNT_W-1:0]   count;

    logic [ROWS-1:0]    enc_mask;
    logic [IDX_W-1:0]   k;
    logic               k_valid;
    logic [ROWS-1:0]    therm;
    logic [ROWS-1:0]    pending_next;
    logic [CNT_W-1:0]   flag_count;
    logic [TOTAL_W:0]   total_sum;
    logic [TOTAL_W-1:0] total_sat;

    // The first shift is planned straight from the flags as they arrive in
    // CAPTURE; later shifts come from the rows still pending.
    assign enc_mask = (state == ST_CAPTURE) ? bus.clear_flags : pending;

    row_pri_enc #(.W(ROWS), .IDX_W(IDX_W)) u_pri_enc (
        .mask  (enc_mask),
        .idx   (k),
        .valid (k_valid)
    );

    always_comb begin
        // NOTE: every variable gets a default before any conditional or loop
        // update, so no path can leave it unassigned and infer a latch.
        flag_count   = '0;
        therm        = '0;
        pending_next = enc_mask;
        for (int i = 0; i < ROWS; i++) begin
            flag_count = flag_count + CNT_W'(bus.clear_flags[i]);
            therm[i]   = (i <= int'(k));
        end
        pending_next[k] = 1'b0;
    end

    assign total_sum = {1'b0, total_lines} + (TOTAL_W + 1)'(count);
    assign total_sat = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            row_cmd       <= ROW_MOVE;
            shift_row     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            total_lines   <= '0;
            pending       <= '0;
            count         <= '0;
        end else begin
            // NOTE: state is updated only with non-blocking assignments so every
            // branch below sees the values from before this edge.
            done      <= 1'b0;
            shift_row <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.lock_req) begin
                        state   <= ST_WRITE;
                        row_cmd <= ROW_WRITE;
                        busy    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state   <= ST_CHECK;
                    row_cmd <= ROW_CHECK;
                end
                ST_CHECK: begin
                    state   <= ST_CAPTURE;
                    row_cmd <= ROW_MOVE;
                end
                ST_CAPTURE: begin
                    count <= flag_count;
                    if (!k_valid) begin
                        state         <= ST_DONE;
                        done          <= 1'b1;
                        lines_cleared <= '0;
                        pending       <= '0;
                    end else begin
                        state     <= ST_SHIFT;
                        row_cmd   <= ROW_SHIFT;
                        shift_row <= therm;
                        pending   <= pending_next;
                    end
                end
                ST_SHIFT: begin
                    // Rows below k never move, so pending indices stay valid.
                    if (pending != '0) begin
                        shift_row <= therm;
                        pending   <= pending_next;
                    end else begin
                        state         <= ST_DONE;
                        row_cmd       <= ROW_MOVE;
                        done          <= 1'b1;
                        lines_cleared <= count;
                        total_lines   <= total_sat;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    row_cmd <= ROW_MOVE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.row_cmd       = row_cmd;
    assign bus.shift_row     = shift_row;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.lines_cleared = lines_cleared;
    assign bus.total_lines   = total_lines;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: a transaction-level model expands each accepted
// lock into its expected per-cycle outputs, compared every cycle.
module tb_line_clear_ctrl;
    import tetris_pkg::*;

    localparam int ROWS = 20;
    localparam int TW   = 16;
    localparam int TW_S = 4;

    typedef struct {
        logic [1:0]      cmd;
        logic [ROWS-1:0] shift;
        logic            busy;
        logic            done;
        logic            capture;
        int              lines;
        int              total;
        int              total_s;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exp_t            q[$];
    logic [ROWS-1:0] cur_plan;
    int              hold_lines   = 0;
    int              hold_total   = 0;
    int              hold_total_s = 0;

    logic [1:0]      obs_cmd[$];
    logic [ROWS-1:0] obs_shift[$];
    logic            obs_done[$];
    logic            obs_busy[$];
    int              obs_lines[$];
    int              obs_total[$];
    int              obs_total_s[$];

    line_clear_ctrl_if #(.ROWS(ROWS), .TOTAL_W(TW))   bus   ();
    line_clear_ctrl_if #(.ROWS(ROWS), .TOTAL_W(TW_S)) bus_s ();

    assign bus_s.lock_req    = bus.lock_req;
    assign bus_s.clear_flags = bus.clear_flags;

    line_clear_ctrl #(.ROWS(ROWS), .TOTAL_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow-total copy so saturation is reachable in a short run.
    line_clear_ctrl #(.ROWS(ROWS), .TOTAL_W(TW_S)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic exp_t idle_rec();
        exp_t e;
        e.cmd = 2'b01; e.shift = '0; e.busy = 1'b0; e.done = 1'b0; e.capture = 1'b0;
        e.lines = hold_lines; e.total = hold_total; e.total_s = hold_total_s;
        return e;
    endfunction

    // One accepted lock: WRITE, CHECK, capture, a shift per flagged row going
    // top-down with every row at or above it enabled, then the done cycle.
    task automatic push_seq(input logic [ROWS-1:0] plan);
        exp_t e;
        int   n;
        n = $countones(plan);
        e = idle_rec();
        e.busy = 1'b1;
        e.cmd = 2'b10; q.push_back(e);
        e.cmd = 2'b00; q.push_back(e);
        e.cmd = 2'b01; e.capture = 1'b1; q.push_back(e);
        e.capture = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (plan[r]) begin
                e.cmd   = 2'b11;
                e.shift = ROWS'((1 << (r + 1)) - 1);
                q.push_back(e);
            end
        end
        e.cmd = 2'b01; e.shift = '0; e.done = 1'b1;
        e.lines   = n;
        e.total   = sat(hold_total + n, TW);
        e.total_s = sat(hold_total_s + n, TW_S);
        q.push_back(e);
    endtask

    task automatic step(input logic lr, input logic [ROWS-1:0] plan);
        exp_t e;
        @(negedge clk);
        e = (q.size() != 0) ? q[0] : idle_rec();
        check("row_cmd",       32'(bus.row_cmd),       32'(e.cmd));
        check("shift_row",     32'(bus.shift_row),     32'(e.shift));
        check("busy",          32'(bus.busy),          32'(e.busy));
        check("done",          32'(bus.done),          32'(e.done));
        check("lines_cleared", 32'(bus.lines_cleared), 32'(e.lines));
        check("total_lines",   32'(bus.total_lines),   32'(e.total));
        check("total_sat4",    32'(bus_s.total_lines), 32'(e.total_s));
        obs_cmd.push_back(bus.row_cmd);
        obs_shift.push_back(bus.shift_row);
        obs_done.push_back(bus.done);
        obs_busy.push_back(bus.busy);
        obs_lines.push_back(int'(bus.lines_cleared));
        obs_total.push_back(int'(bus.total_lines));
        obs_total_s.push_back(int'(bus_s.total_lines));

        bus.clear_flags = e.capture ? cur_plan : ROWS'($urandom);
        bus.lock_req    = lr;
        if (q.size() != 0) begin
            if (q[0].done) begin
                hold_lines   = q[0].lines;
                hold_total   = q[0].total;
                hold_total_s = q[0].total_s;
            end
            void'(q.pop_front());
        end else if (lr) begin
            cur_plan = plan;
            push_seq(plan);
        end
    endtask

    task automatic clear_obs();
        obs_cmd.delete(); obs_shift.delete(); obs_done.delete(); obs_busy.delete();
        obs_lines.delete(); obs_total.delete(); obs_total_s.delete();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0) begin
            step(1'b0, '0);
            guard++;
            if (guard > 100) begin
                check("drain_budget", 32'(guard), 32'(100));
                break;
            end
        end
    endtask

    task automatic run_lock(input logic [ROWS-1:0] plan);
        clear_obs();
        step(1'b1, plan);
        drain();
    endtask

    function automatic int done_count();
        int c;
        c = 0;
        foreach (obs_done[i]) c += int'(obs_done[i]);
        return c;
    endfunction

    initial begin
        logic            lr;
        logic [ROWS-1:0] p;
        logic [ROWS-1:0] acc;
        int              last;

        reset = 1'b0;
        bus.lock_req    = 1'b0;
        bus.clear_flags = '0;
        #1 reset = 1'b1;
        #2;
        check("reset_row_cmd", 32'(bus.row_cmd),       32'h1);
        check("reset_shift",   32'(bus.shift_row),     32'h0);
        check("reset_busy",    32'(bus.busy),          32'h0);
        check("reset_done",    32'(bus.done),          32'h0);
        check("reset_lines",   32'(bus.lines_cleared), 32'h0);
        check("reset_total",   32'(bus.total_lines),   32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // No clear: command sequence and 4-cycle latency.
        run_lock('0);
        check("nc_cmd1", 32'(obs_cmd[1]), 32'h2);
        check("nc_cmd2", 32'(obs_cmd[2]), 32'h0);
        check("nc_cmd3", 32'(obs_cmd[3]), 32'h1);
        check("nc_cmd4", 32'(obs_cmd[4]), 32'h1);
        check("nc_done_at4", 32'(obs_done[4]), 32'h1);
        check("nc_lines", 32'(obs_lines[4]), 32'h0);
        acc = '0;
        foreach (obs_shift[i]) acc |= obs_shift[i];
        check("nc_shift_quiet", 32'(acc), 32'h0);

        // Bottom row only.
        run_lock(20'h80000);
        check("b19_cmd",   32'(obs_cmd[4]),   32'h3);
        check("b19_shift", 32'(obs_shift[4]), 32'hFFFFF);
        check("b19_done",  32'(obs_done[5]),  32'h1);
        check("b19_lines", 32'(obs_lines[5]), 32'h1);
        check("b19_total", 32'(obs_total[5]), 32'h1);

        // Rows 12 and 15, non-contiguous.
        run_lock(20'h09000);
        check("nc2_shift1", 32'(obs_shift[4]), 32'h01FFF);
        check("nc2_shift2", 32'(obs_shift[5]), 32'h0FFFF);
        check("nc2_lines",  32'(obs_lines[6]), 32'h2);
        check("nc2_total",  32'(obs_total[6]), 32'h3);

        // Rows 16..19, contiguous.
        run_lock(20'hF0000);
        check("c4_shift1", 32'(obs_shift[4]), 32'h1FFFF);
        check("c4_shift2", 32'(obs_shift[5]), 32'h3FFFF);
        check("c4_shift3", 32'(obs_shift[6]), 32'h7FFFF);
        check("c4_shift4", 32'(obs_shift[7]), 32'hFFFFF);
        check("c4_lines",  32'(obs_lines[8]), 32'h4);
        check("c4_total",  32'(obs_total[8]), 32'h7);

        // Lock requests during SHIFT and in the done cycle are dropped.
        clear_obs();
        step(1'b1, 20'h09000);
        repeat (3) step(1'b0, '0);
        step(1'b1, '1);
        step(1'b0, '0);
        step(1'b1, '1);
        repeat (4) step(1'b0, '0);
        check("rej_in_shift", 32'(obs_cmd[4]), 32'h3);
        check("rej_done_at6", 32'(obs_done[6]), 32'h1);
        check("rej_one_done", 32'(done_count()), 32'h1);
        check("rej_no_write", 32'(obs_cmd[7]), 32'h1);
        check("rej_idle_cmd", 32'(obs_cmd[10]), 32'h1);
        check("rej_idle_busy", 32'(obs_busy[10]), 32'h0);

        // Every row full.
        run_lock('1);
        last = obs_done.size() - 1;
        check("all_first_shift", 32'(obs_shift[4]),  32'h00001);
        check("all_last_shift",  32'(obs_shift[23]), 32'hFFFFF);
        check("all_done_at24",   32'(obs_done[24]),  32'h1);
        check("all_lines",       32'(obs_lines[last]), 32'd20);
        check("all_total",       32'(obs_total[last]), 32'd29);
        check("all_total_sat4",  32'(obs_total_s[last]), 32'hF);

        // Asynchronous reset between edges in the middle of SHIFT.
        clear_obs();
        step(1'b1, 20'hF0000);
        repeat (5) step(1'b0, '0);
        check("mid_in_shift", 32'(obs_cmd[5]), 32'h3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cmd",   32'(bus.row_cmd),     32'h1);
        check("mid_rst_shift", 32'(bus.shift_row),   32'h0);
        check("mid_rst_busy",  32'(bus.busy),        32'h0);
        check("mid_rst_total", 32'(bus.total_lines), 32'h0);
        bus.lock_req = 1'b0;
        q.delete();
        hold_lines = 0; hold_total = 0; hold_total_s = 0;
        @(posedge clk);
        #1 check("mid_rst_hold", 32'(bus.row_cmd), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // Saturation on the narrow total: 4+4+4+2 = 14, then +3 pins at 15.
        run_lock(20'hF0000);
        run_lock(20'hF0000);
        run_lock(20'hF0000);
        run_lock(20'h00003);
        last = obs_done.size() - 1;
        check("sat_pre", 32'(obs_total_s[last]), 32'hE);
        run_lock(20'h00007);
        last = obs_done.size() - 1;
        check("sat_total",  32'(obs_total_s[last]), 32'hF);
        check("sat_lines",  32'(obs_lines[last]),   32'h3);
        check("sat_wide",   32'(obs_total[last]),   32'd17);
        run_lock(20'h00001);
        last = obs_done.size() - 1;
        check("sat_stays",  32'(obs_total_s[last]), 32'hF);

        // Randomized traffic, including requests while busy.
        for (int i = 0; i < 1500; i++) begin
            lr = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       p = '0;
                1:       p = ROWS'(1) << $urandom_range(0, ROWS - 1);
                2:       p = ROWS'($urandom) & ROWS'($urandom);
                default: p = ROWS'($urandom);
            endcase
            step(lr, p);
        end
        drain();
        step(1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
